// File: rtl/mfrc_spi_sched.sv
// mfrc_spi_sched: round-robin scheduler sharing one SPI_master (MFRC522
// register port) between NUM_REQ requesters. Single-byte read/write per
// transaction, one transaction outstanding at a time.
// Optional watchdog on the WAIT state: define MFRC_SPI_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps

module mfrc_spi_sched #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_error,
    output logic                   spi_en,
    output logic                   spi_rw,
    output logic [6:0]             spi_addr,
    output logic [7:0]             spi_data_in,
    output logic [7:0]             spi_num_bytes,
    input  logic [7:0]             spi_data_out,
    input  logic                   spi_busy,
    input  logic                   spi_done,
    input  logic                   spi_error
);

    localparam int                 PTR_W    = $clog2(NUM_REQ);
    localparam int unsigned        NREQ_U   = NUM_REQ;
    localparam logic [PTR_W-1:0]   LAST_REQ = PTR_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mfrc_spi_sched: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   grant_q, grant_d;
    logic               spi_rw_q, spi_rw_d;
    logic [6:0]         spi_addr_q, spi_addr_d;
    logic [7:0]         spi_wdata_q, spi_wdata_d;
    logic [7:0]         rsp_rdata_q, rsp_rdata_d;
    logic               rsp_error_q, rsp_error_d;

    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    logic               accept;
    logic               wd_expired;

    logic [6:0]         addr_arr  [NUM_REQ];
    logic [7:0]         wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[7*gi +: 7];
        assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            cand = PTR_W'((32'(rr_ptr_q) + i) % NREQ_U);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Handshake and pulse outputs decoded from the current state.
    always_comb begin
        accept    = axi_aresetn && (state_q == S_IDLE) && !spi_busy && grant_any;
        req_ready = '0;
        rsp_valid = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state_q == S_RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
    end

`ifdef MFRC_SPI_SCHED_TIMEOUT_EN
    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Watchdog: cleared in LAUNCH, counts each WAIT cycle; expiry on the
    // TIMEOUT_CYCLES-th WAIT cycle.
    always_comb begin
        wd_d       = wd_q;
        wd_expired = (state_q == S_WAIT) && (wd_q == WD_LAST);
        if (state_q == S_LAUNCH) begin
            wd_d = '0;
        end else if (state_q == S_WAIT && !wd_expired) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    // Next-state logic: accept, launch, wait for done/expiry, respond.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        spi_rw_d    = spi_rw_q;
        spi_addr_d  = spi_addr_q;
        spi_wdata_d = spi_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    grant_d     = grant_idx;
                    rr_ptr_d    = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
                    spi_rw_d    = req_rw[grant_idx];
                    spi_addr_d  = addr_arr[grant_idx];
                    spi_wdata_d = wdata_arr[grant_idx];
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done has priority over a coincident watchdog expiry
                if (spi_done) begin
                    rsp_rdata_d = spi_rw_q ? spi_data_out : 8'h00;
                    rsp_error_d = spi_error;
                    state_d     = S_RESP;
                end else if (wd_expired) begin
                    rsp_rdata_d = 8'h00;
                    rsp_error_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            spi_rw_q    <= 1'b0;
            spi_addr_q  <= '0;
            spi_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            spi_rw_q    <= spi_rw_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign spi_en        = (state_q == S_LAUNCH);
    assign spi_rw        = spi_rw_q;
    assign spi_addr      = spi_addr_q;
    assign spi_data_in   = spi_wdata_q;
    assign spi_num_bytes = 8'd1;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_mfrc_spi_sched.sv
// Testbench for mfrc_spi_sched: directed scenarios plus randomized traffic,
// expected responses queued by the stimulus side and checked by a monitor.
`timescale 1ns/1ps

module tb_mfrc_spi_sched;

    localparam int N  = 2;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N-1:0]     req_valid, req_ready, req_rw, rsp_valid;
    logic [7*N-1:0]   req_addr;
    logic [8*N-1:0]   req_wdata;
    logic [7:0]       rsp_rdata, spi_data_in, spi_num_bytes, spi_data_out;
    logic             rsp_error, spi_en, spi_rw, spi_busy, spi_done, spi_error;
    logic [6:0]       spi_addr;

    always #5 clk = ~clk;

    mfrc_spi_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .axi_aclk(clk), .axi_aresetn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .spi_en(spi_en), .spi_rw(spi_rw), .spi_addr(spi_addr),
        .spi_data_in(spi_data_in), .spi_num_bytes(spi_num_bytes),
        .spi_data_out(spi_data_out), .spi_busy(spi_busy),
        .spi_done(spi_done), .spi_error(spi_error)
    );

    typedef struct {
        int         id;
        logic [7:0] rdata;
        logic       err;
        int         at;
    } rsp_t;

    rsp_t sb[$];
    int   grants[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // reference model state
    bit         pend [N];
    logic       p_rw [N];
    logic [6:0] p_addr [N];
    logic [7:0] p_wdata [N];
    int         ptr = 0;
    bit         model_idle = 1;
    bit         launch_exp = 0;
    int         rsp_due = -1;
    logic       acc_rw = 1'b0;
    logic [6:0] acc_addr = '0;
    logic [7:0] acc_wdata = '0;
    int         cur_req = 0;
    bit         in_txn = 0;
    int         wcnt = 0;
    int         gen_mode = 0;   // 0 none, 1 random, 2 hold all high
    bit         hang = 0;
    bit         slow = 0;
    bit         force_busy = 0;
    bit         fix_en = 0;
    logic [7:0] fix_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_req(input int i);
        pend[i]    = 1;
        p_rw[i]    = 1'($urandom);
        p_addr[i]  = 7'($urandom);
        p_wdata[i] = 8'($urandom);
    endtask

    function automatic bit pend_none();
        for (int i = 0; i < N; i++) if (pend[i]) return 0;
        return 1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"},   32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"},   32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"},   32'(rsp_rdata), 32'd0);
        check({tag, "_rsp_error"},   32'(rsp_error), 32'd0);
        check({tag, "_spi_en"},      32'(spi_en), 32'd0);
        check({tag, "_spi_rw"},      32'(spi_rw), 32'd0);
        check({tag, "_spi_addr"},    32'(spi_addr), 32'd0);
        check({tag, "_spi_data_in"}, 32'(spi_data_in), 32'd0);
        check({tag, "_spi_nbytes"},  32'(spi_num_bytes), 32'd1);
    endtask

    // One clock of stimulus, SPI_master model and arbitration prediction.
    task automatic step();
        logic [N-1:0] exp_ready;
        int           g;
        logic [7:0]   d;
        logic         e;
        rsp_t         r;
        @(negedge clk);
        cyc++;
        if (!model_idle && rsp_due >= 0 && cyc == rsp_due + 1) begin
            model_idle = 1;
            rsp_due    = -1;
        end
        check("spi_en", 32'(spi_en), 32'(launch_exp));
        check("spi_num_bytes", 32'(spi_num_bytes), 32'd1);
        check("spi_rw_hold", 32'(spi_rw), 32'(acc_rw));
        check("spi_addr_hold", 32'(spi_addr), 32'(acc_addr));
        check("spi_data_in_hold", 32'(spi_data_in), 32'(acc_wdata));
        // SPI_master model
        spi_done = 1'b0;
        if (in_txn) begin
            spi_busy = 1'b1;
            if (wcnt == 0) begin
                d = fix_en ? fix_data : 8'($urandom);
                e = fix_en ? 1'b0 : ($urandom % 6 == 0);
                spi_done = 1'b1; spi_data_out = d; spi_error = e;
                r.id = cur_req; r.rdata = acc_rw ? d : 8'h00; r.err = e; r.at = cyc + 1;
                sb.push_back(r);
                rsp_due = cyc + 1;
                in_txn  = 0;
            end else begin
                wcnt--;
            end
        end else begin
            spi_busy = force_busy || (gen_mode == 1 && $urandom % 5 == 0);
            if (model_idle && gen_mode == 1 && $urandom % 6 == 0) begin
                spi_done = 1'b1; spi_data_out = 8'($urandom); spi_error = 1'($urandom);
            end
        end
        if (launch_exp) begin
            launch_exp = 0;
            if (hang) begin
                r.id = cur_req; r.rdata = 8'h00; r.err = 1'b1; r.at = cyc + 1 + TO;
                sb.push_back(r);
                rsp_due = cyc + 1 + TO;
            end else begin
                in_txn = 1;
                wcnt   = slow ? 20 : int'($urandom_range(0, 5));
            end
        end
        // requesters
        for (int i = 0; i < N; i++) begin
            if (gen_mode == 2 && !pend[i]) new_req(i);
            else if (gen_mode == 1) begin
                if (!pend[i] && $urandom % 4 == 0) new_req(i);
                else if (pend[i] && $urandom % 16 == 0) pend[i] = 0;
            end
            req_valid[i]         = pend[i];
            req_rw[i]            = p_rw[i];
            req_addr[7*i +: 7]   = p_addr[i];
            req_wdata[8*i +: 8]  = p_wdata[i];
        end
        #1;
        // arbitration prediction for the coming edge
        g = -1;
        if (model_idle && !spi_busy) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        for (int k = 0; k < N; k++) if (req_ready[k] && req_valid[k]) grants.push_back(k);
        if (g >= 0) begin
            acc_rw = p_rw[g]; acc_addr = p_addr[g]; acc_wdata = p_wdata[g];
            cur_req = g; pend[g] = 0; ptr = (g + 1) % N;
            model_idle = 0; launch_exp = 1;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (k < budget && !(model_idle && !launch_exp && pend_none() && sb.size() == 0)) begin
            step();
            k++;
        end
        n_cmp++;
        if (k >= budget) begin
            n_fail++;
            $display("FAIL %s: not idle after %0d cycles, %0d responses outstanding", name, budget, sb.size());
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        cyc++;
        #2 rstn = 1'b0;
        sb.delete();
        model_idle = 1; ptr = 0; launch_exp = 0; in_txn = 0; rsp_due = -1;
        acc_rw = 1'b0; acc_addr = '0; acc_wdata = '0;
        spi_done = 1'b0; spi_busy = 1'b0;
        #1 check_reset_vals("midrst");
        @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    // Response monitor: pops the scoreboard whenever a response appears.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rstn && rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid %0b with no response expected (cycle %0d)", rsp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(N'(1) << e.id));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    check("rsp_error", 32'(rsp_error), 32'(e.err));
                    check("rsp_cycle", 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int exp_order[4];
        int k;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; p_rw[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
        end
        rstn = 1'b0; req_valid = '1; req_rw = '0; req_addr = '0; req_wdata = '0;
        spi_data_out = 8'h5A; spi_busy = 1'b0; spi_done = 1'b1; spi_error = 1'b0;
        @(negedge clk);
        #1 check_reset_vals("rst");
        @(posedge clk);
        #2 rstn = 1'b1; spi_done = 1'b0; req_valid = '0;

        // single write on requester 0; SPI data must not leak into rdata
        new_req(0); p_rw[0] = 1'b0; p_addr[0] = 7'h01; p_wdata[0] = 8'h55;
        fix_en = 1; fix_data = 8'hA7;
        drain("write_req0", 50);

        // single read on requester 1
        new_req(1); p_rw[1] = 1'b1; p_addr[1] = 7'h37;
        fix_data = 8'h91;
        drain("read_req1", 50);
        fix_en = 0;

        // both held high: strict alternation starting from requester 0
        grants.delete();
        gen_mode = 2;
        k = 0;
        while (grants.size() < 4 && k < 200) begin step(); k++; end
        gen_mode = 0;
        drain("hold_both", 100);
        exp_order = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++)
            check($sformatf("grant_order_%0d", i),
                  (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));

        // spi_busy stalls acceptance in IDLE
        force_busy = 1;
        new_req(0);
        repeat (6) step();
        force_busy = 0;
        grants.delete();
        step();
        check("busy_release_grant", (grants.size() == 1) ? 32'(grants[0]) : 32'hFFFF_FFFF, 32'd0);
        drain("busy_release", 50);

`ifdef MFRC_SPI_SCHED_TIMEOUT_EN
        // hung SPI_master: watchdog completes with error, next request proceeds
        hang = 1;
        new_req(0);
        drain("timeout", 200);
        hang = 0;
        new_req(1);
        drain("after_timeout", 50);
`endif

        // randomized traffic with drops, busy stalls and stray done pulses
        gen_mode = 1;
        repeat (1500) step();
        gen_mode = 0;
        drain("random", 400);

        // reset during WAIT drops the transaction and restarts at requester 0
        slow = 1;
        new_req(1);
        k = 0;
        while (!in_txn && k < 30) begin step(); k++; end
        repeat (3) step();
        reset_mid();
        slow = 0;
        new_req(0);
        new_req(1);
        grants.delete();
        drain("after_reset", 100);
        check("grant_after_reset", (grants.size() > 0) ? 32'(grants[0]) : 32'hFFFF_FFFF, 32'd0);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
